// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler.
// Edges are latched per channel and delivered one at a time over a
// valid/ready slot, using round-robin arbitration and sticky overflow flags.
module edge_event_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_sig,
  input  logic [N-1:0]   i_en,
  output logic           o_evt_valid,
  output logic [IDW-1:0] o_evt_id,
  input  logic           i_evt_ready,
  output logic [N-1:0]   o_pending,
  output logic [N-1:0]   o_ovf,
  input  logic [N-1:0]   i_ovf_clr
);

  // The candidate index is one bit wider so rr_last + k never wraps before the modulo step
  localparam int            CW      = IDW + 1;
  localparam logic [N-1:0]  ONE_HOT = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]   r_sig_q;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   r_ovf;
  logic           r_evt_valid;
  logic [IDW-1:0] r_evt_id;
  logic [IDW-1:0] r_rr_last;

  logic [N-1:0]   w_edge;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_pending_nxt;
  logic [N-1:0]   w_ovf_nxt;
  logic           w_load;
  logic           w_found;
  logic [IDW-1:0] w_grant;
  logic [CW-1:0]  w_cand;

  assign w_edge = i_sig & ~r_sig_q & i_en;
  assign w_load = (|r_pending) & (~r_evt_valid | i_evt_ready);

  // Round-robin search starting one past the last granted channel
  always_comb begin
    w_grant = {IDW{1'b0}};
    w_found = 1'b0;
    w_cand  = {CW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      w_cand = {1'b0, r_rr_last} + CW'(k);
      if (w_cand >= CW'(N)) begin
        w_cand = w_cand - CW'(N);
      end else begin
        w_cand = w_cand;
      end
      if (!w_found && r_pending[w_cand[IDW-1:0]]) begin
        w_grant = w_cand[IDW-1:0];
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // A new edge on the channel being loaded re-arms it instead of counting as lost
  assign w_clr         = w_load ? (ONE_HOT << w_grant) : {N{1'b0}};
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
  assign w_ovf_nxt     = (w_edge & r_pending & ~w_clr) | (r_ovf & ~i_ovf_clr);

  // Per-channel edge history, pending and overflow state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_q   <= {N{1'b0}};
      r_pending <= {N{1'b0}};
      r_ovf     <= {N{1'b0}};
    end else begin
      r_sig_q   <= i_sig;
      r_pending <= w_pending_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  // Output slot: id is frozen while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= {IDW{1'b0}};
      r_rr_last   <= IDW'(N - 1);
    end else if (w_load) begin
      r_evt_valid <= 1'b1;
      r_evt_id    <= w_grant;
      r_rr_last   <= w_grant;
    end else if (r_evt_valid && i_evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_id    = r_evt_id;
  assign o_pending   = r_pending;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed, table-driven bench for edge_event_arbiter (N=4) with
// hand-written sequences for the asynchronous mid-operation reset.
module tb_edge_event_arbiter;

  typedef struct packed {
    logic [3:0] sig;
    logic [3:0] en;
    logic       rdy;
    logic [3:0] clr;
    logic       v;
    logic [1:0] id;
    logic [3:0] p;
    logic [3:0] o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig, en, ovf_clr;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending, ovf;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  edge_event_arbiter #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sig       (sig),
    .i_en        (en),
    .o_evt_valid (evt_valid),
    .o_evt_id    (evt_id),
    .i_evt_ready (evt_ready),
    .o_pending   (pending),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic v, input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
    check("evt_valid", row, {7'd0, evt_valid}, {7'd0, v});
    check("evt_id",    row, {6'd0, evt_id},    {6'd0, id});
    check("pending",   row, {4'd0, pending},   {4'd0, p});
    check("ovf",       row, {4'd0, ovf},       {4'd0, o});
  endtask

  task automatic add(input logic [3:0] s, input logic [3:0] e, input logic r, input logic [3:0] c,
                     input logic v, input logic [1:0] id, input logic [3:0] p, input logic [3:0] o);
    tbl.push_back('{s, e, r, c, v, id, p, o});
  endtask

  initial begin
    // sig en rdy clr | valid id pending ovf
    // reset release with all inputs high: events 0,1,2,3 back to back
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 4'hF, 4'h0);
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 4'hE, 4'h0);
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 4'hC, 4'h0);
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 4'h8, 4'h0);
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 4'h0, 4'h0);
    add(4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 4'h0, 4'h0);
    // single edge on ch2, valid for exactly one cycle
    add(4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 4'h0, 4'h0);
    add(4'h4, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 4'h4, 4'h0);
    add(4'h4, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 4'h0, 4'h0);
    add(4'h4, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 4'h0, 4'h0);
    // serve ch1, then 1011 at once -> 3, 0, 1
    add(4'h6, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 4'h2, 4'h0);
    add(4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 4'hB, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 4'h3, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 4'h2, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 4'h0, 4'h0);
    // backpressure on ch1, overflow, clear, set-beats-clear
    add(4'h9, 4'hF, 1'b0, 4'h0, 1'b0, 2'd1, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b0, 4'h0, 1'b0, 2'd1, 4'h2, 4'h0);
    add(4'h9, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h0);
    add(4'h9, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h0);
    add(4'hB, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h2);
    add(4'hB, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2, 4'h0);
    add(4'h9, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h0);
    add(4'hB, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2, 4'h2);
    add(4'hB, 4'hF, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1, 4'h0, 4'h0);
    // edge on ch0 in the same cycle ch0 loads: delivered twice, no overflow
    add(4'h2, 4'hF, 1'b0, 4'h0, 1'b0, 2'd1, 4'h0, 4'h0);
    add(4'hA, 4'hF, 1'b0, 4'h0, 1'b0, 2'd1, 4'h8, 4'h0);
    add(4'hB, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 4'h1, 4'h0);
    add(4'hA, 4'hF, 1'b0, 4'h0, 1'b1, 2'd3, 4'h1, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 4'h1, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    // masked edge on ch3, then enabling while high creates nothing
    add(4'h3, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    add(4'hB, 4'h7, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);
    add(4'hB, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0);

    rst       = 1'b1;
    sig       = 4'hF;
    en        = 4'hF;
    evt_ready = 1'b1;
    ovf_clr   = 4'h0;
    step();
    step();
    check_all(-1, 1'b0, 2'd0, 4'h0, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      sig       = tbl[i].sig;
      en        = tbl[i].en;
      evt_ready = tbl[i].rdy;
      ovf_clr   = tbl[i].clr;
      step();
      check_all(i, tbl[i].v, tbl[i].id, tbl[i].p, tbl[i].o);
    end

    // build valid slot + pending + overflow on ch0 under backpressure
    evt_ready = 1'b0;
    en        = 4'hF;
    sig = 4'hA; step();
    sig = 4'hB; step();
    sig = 4'hA; step();
    sig = 4'hB; step();
    sig = 4'hA; step();
    sig = 4'hB; step();
    check_all(100, 1'b1, 2'd0, 4'h1, 4'h1);

    // asynchronous reset between clock edges clears everything at once
    #2;
    rst = 1'b1;
    #1;
    check_all(101, 1'b0, 2'd0, 4'h0, 4'h0);
    step();
    step();
    evt_ready = 1'b1;
    rst       = 1'b0;
    step();
    check_all(102, 1'b0, 2'd0, 4'hB, 4'h0);
    step();
    check_all(103, 1'b1, 2'd0, 4'hA, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
